dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port between the pipeline MEM stage (core) and an
//  external loader/debug requester (ext). The core is pass-through with zero added
//  latency. The ext side gets a valid/ready handshake and registered read data.
//  A starvation counter forces an ext grant by stalling the core for one cycle.
//  Sits between the memory-stage datapath and the data memory macro.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive cycles ext_valid may be refused before a forced grant (>=1)
//  CNT_W         3   width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   asynchronous, active-low reset
//  core_req     in   1   MEM-stage access this cycle (store or load)
//  core_we      in   1   core store enable (MemWriteM)
//  core_funct3  in   3   core access size/sign (InstrM[14:12])
//  core_addr    in   32  core byte address (ALUResultM)
//  core_wdata   in   32  core store data (WriteDataM)
//  core_rdata   out  32  load data to MEM/WB register (= mem_rdata)
//  stall_m      out  1   freeze IF..MEM and hold core request; MEM/WB gets bubble
//  ext_valid    in   1   ext request pending; fields held stable until ext_ready
//  ext_ready    out  1   ext request accepted this cycle
//  ext_we       in   1   ext write enable
//  ext_funct3   in   3   ext access size/sign
//  ext_addr     in   32  ext byte address
//  ext_wdata    in   32  ext write data
//  ext_rvalid   out  1   one-cycle pulse: ext_rdata valid
//  ext_rdata    out  32  registered read data of last accepted ext access
//  mem_we       out  1   to data memory: write enable (written on posedge)
//  mem_funct3   out  3   to data memory: size/sign
//  mem_addr     out  32  to data memory: address
//  mem_wdata    out  32  to data memory: write data
//  mem_rdata    in   32  from data memory: combinational read data
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, starve_cnt=0, ext_rvalid=0, ext_rdata=0.
//    Combinational outputs are then ext_ready=0, stall_m=0, mem_we=0.
//  - FSM states:
//    - IDLE: normal arbitration.
//    - GAP: the cycle after any ext grant. Ext is never granted here (ext_ready=0),
//      so the core is guaranteed progress. GAP->IDLE unconditionally.
//  - ext_grant (combinational):
//    - state==IDLE && ext_valid && (!core_req || starve_cnt==STARVE_LIMIT).
//    - ext_ready = ext_grant.
//    - stall_m = ext_grant && core_req.
//  - Mux: ext_grant selects ext_* onto mem_*; otherwise core_* is selected.
//    - mem_we = ext_grant ? ext_we : (core_req && core_we).
//    - When not ext_grant, the core path has zero latency.
//  - Transitions: IDLE->GAP on ext_grant.
//  - ext read path: on posedge with ext_grant && !ext_we, ext_rdata<=mem_rdata and
//    ext_rvalid<=1 in the next cycle. Otherwise ext_rvalid<=0 and ext_rdata holds.
//    Ext writes produce no ext_rvalid.
//  - starve_cnt update, in priority order:
//    - cleared on ext_grant or !ext_valid;
//    - else incremented when ext_valid && core_req && state==IDLE (refused);
//    - else held (e.g. in GAP). Saturates at STARVE_LIMIT.
//  - A forced grant stalls the core exactly one cycle. The held core request is
//    serviced in the following GAP cycle.
//  - core_rdata is always mem_rdata. The core ignores it while stall_m=1.
//  - No ext starvation: worst-case ext wait = STARVE_LIMIT+1 cycles from IDLE.
//  - Reset mid-access: any in-flight ext read is dropped (no ext_rvalid). The
//    requester must re-issue.
//  - Ext request fields are sampled only in the grant cycle. Changing them while
//    ext_valid=1 && ext_ready=0 is legal; the value in the grant cycle is used.
// TESTING
//  1. Reset: rst=0 with ext_valid=1, core_req=1 -> ext_ready=0, stall_m=0,
//     ext_rvalid=0, mem_addr=core_addr. Release: first grant only after the
//     starvation rule.
//  2. Idle-core ext write: core_req=0, ext_valid=1, ext_we=1, addr=0x40, wdata=0xDEADBEEF
//     -> ext_ready=1 the same cycle, mem_we=1, stall_m=0. The core then loads 0x40
//     (funct3=010) -> core_rdata=0xDEADBEEF.
//  3. Ext read: mem holds 0x12345678 @0x80; ext_valid=1, ext_we=0, addr=0x80, core idle
//     -> next cycle ext_rvalid=1 (single pulse), ext_rdata=0x12345678.
//  4. Starvation, STARVE_LIMIT=4: core_req=1 continuously and ext_valid=1
//     -> ext refused for 4 cycles. 5th cycle: ext_ready=1, stall_m=1. 6th cycle (GAP):
//     core serviced, stall_m=0. starve_cnt=0.
//  5. Back-to-back ext with core idle: ext_valid held high for 3 requests
//     -> ext_ready pattern 1,0,1,0,1 (GAP enforced). ext_rvalid follows each read by 1 cycle.
//  6. Async reset mid-read: assert rst=0 between the grant posedge and the next edge
//     -> ext_rvalid stays 0, ext_rdata=0, state IDLE after release.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Data-memory port bundle: core (MEM stage) request, ext loader/debug handshake,
// and the single shared memory macro port.
interface dmem_arbiter_if;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        stall_m;

    logic        ext_valid;
    logic        ext_ready;
    logic        ext_we;
    logic [2:0]  ext_funct3;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;

    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_funct3, core_addr, core_wdata,
        output core_rdata, stall_m,
        input  ext_valid, ext_we, ext_funct3, ext_addr, ext_wdata,
        output ext_ready, ext_rvalid, ext_rdata,
        output mem_we, mem_funct3, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_funct3, core_addr, core_wdata,
        input  core_rdata, stall_m,
        output ext_valid, ext_we, ext_funct3, ext_addr, ext_wdata,
        input  ext_ready, ext_rvalid, ext_rdata,
        input  mem_we, mem_funct3, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the pipeline MEM stage (zero-latency path)
// and an external valid/ready requester, with a starvation-forced ext grant.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, GAP = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   starve_cnt_r;
    logic [CNT_W-1:0]   starve_cnt_s;
    logic               ext_grant_s;
    logic               ext_rvalid_r;
    logic [31:0]        ext_rdata_r;
    logic               mem_we_s;
    logic [2:0]         mem_funct3_s;
    logic [31:0]        mem_addr_s;
    logic [31:0]        mem_wdata_s;

    // Grant decision, next state, starvation count and memory port mux
    always_comb begin
        ext_grant_s  = 1'b0;
        state_s      = state_r;
        starve_cnt_s = starve_cnt_r;
        mem_we_s     = 1'b0;
        mem_funct3_s = bus.core_funct3;
        mem_addr_s   = bus.core_addr;
        mem_wdata_s  = bus.core_wdata;

        // Gating with rst keeps the port quiet (no grant, no write) while in reset
        if (rst && (state_r == IDLE) && bus.ext_valid &&
            (!bus.core_req || (starve_cnt_r == LIMIT))) begin
            ext_grant_s = 1'b1;
        end else begin
            ext_grant_s = 1'b0;
        end

        case (state_r)
            IDLE: begin
                if (ext_grant_s) begin
                    state_s = GAP;
                end else begin
                    state_s = IDLE;
                end
            end
            GAP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase

        if (ext_grant_s || !bus.ext_valid) begin
            starve_cnt_s = {CNT_W{1'b0}};
        end else if (bus.core_req && (state_r == IDLE)) begin
            if (starve_cnt_r < LIMIT) begin
                starve_cnt_s = starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                starve_cnt_s = starve_cnt_r;
            end
        end else begin
            starve_cnt_s = starve_cnt_r;
        end

        if (ext_grant_s) begin
            mem_we_s     = bus.ext_we;
            mem_funct3_s = bus.ext_funct3;
            mem_addr_s   = bus.ext_addr;
            mem_wdata_s  = bus.ext_wdata;
        end else begin
            mem_we_s     = rst && bus.core_req && bus.core_we;
            mem_funct3_s = bus.core_funct3;
            mem_addr_s   = bus.core_addr;
            mem_wdata_s  = bus.core_wdata;
        end
    end

    // FSM state and starvation counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

    // Ext read return: capture memory data for granted reads, pulse rvalid once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_rvalid_r <= 1'b0;
            ext_rdata_r  <= 32'h0000_0000;
        end else if (ext_grant_s && !bus.ext_we) begin
            ext_rvalid_r <= 1'b1;
            ext_rdata_r  <= bus.mem_rdata;
        end else begin
            ext_rvalid_r <= 1'b0;
            ext_rdata_r  <= ext_rdata_r;
        end
    end

    assign bus.ext_ready  = ext_grant_s;
    assign bus.stall_m    = ext_grant_s && bus.core_req;
    assign bus.core_rdata = bus.mem_rdata;
    assign bus.ext_rvalid = ext_rvalid_r;
    assign bus.ext_rdata  = ext_rdata_r;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_funct3 = mem_funct3_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model behind
// the shared port; inputs change #1 after posedge, outputs are checked on negedge.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] mem [0:63];

    dmem_arbiter_if bus();

    dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    // Memory model: preload port for setup, otherwise written from the shared port
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_funct3 = 3'b010;
        bus.core_addr = 32'h0; bus.core_wdata = 32'h0;
        bus.ext_valid = 1'b0; bus.ext_we = 1'b0; bus.ext_funct3 = 3'b010;
        bus.ext_addr = 32'h0; bus.ext_wdata = 32'h0;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        next_cycle();
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        next_cycle();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.core_req = 1'b1; bus.core_addr = 32'h0000_0100;
        bus.ext_valid = 1'b1; bus.ext_addr = 32'h0000_0200;
        @(negedge clk);
        tests++; if (bus.ext_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", bus.ext_ready); end
        tests++; if (bus.stall_m !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", bus.stall_m); end
        tests++; if (bus.ext_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b exp 0", bus.ext_rvalid); end
        tests++; if (bus.mem_addr !== 32'h0000_0100) begin fails++; $display("FAIL reset_mem_addr got %h exp 00000100", bus.mem_addr); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b exp 0", bus.mem_we); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        tests++; if (bus.ext_ready !== 1'b0) begin fails++; $display("FAIL reset_first_cycle_ready got %b exp 0", bus.ext_ready); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_ext_write();
        bus.ext_valid = 1'b1; bus.ext_we = 1'b1; bus.ext_funct3 = 3'b010;
        bus.ext_addr = 32'h0000_0040; bus.ext_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++; if (bus.ext_ready !== 1'b1) begin fails++; $display("FAIL wr_ready got %b exp 1", bus.ext_ready); end
        tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL wr_mem_we got %b exp 1", bus.mem_we); end
        tests++; if (bus.stall_m !== 1'b0) begin fails++; $display("FAIL wr_stall got %b exp 0", bus.stall_m); end
        tests++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_mem_wdata got %h exp deadbeef", bus.mem_wdata); end
        next_cycle();
        bus.ext_valid = 1'b0;
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_funct3 = 3'b010; bus.core_addr = 32'h0000_0040;
        @(negedge clk);
        tests++; if (bus.core_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_core_load got %h exp deadbeef", bus.core_rdata); end
        tests++; if (bus.mem_funct3 !== 3'b010) begin fails++; $display("FAIL wr_core_funct3 got %b exp 010", bus.mem_funct3); end
        tests++; if (bus.ext_rvalid !== 1'b0) begin fails++; $display("FAIL wr_no_rvalid got %b exp 0", bus.ext_rvalid); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_ext_read();
        preload(6'h20, 32'h1234_5678);
        bus.ext_valid = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h0000_0080;
        @(negedge clk);
        tests++; if (bus.ext_ready !== 1'b1) begin fails++; $display("FAIL rd_ready got %b exp 1", bus.ext_ready); end
        tests++; if (bus.ext_rvalid !== 1'b0) begin fails++; $display("FAIL rd_rvalid_early got %b exp 0", bus.ext_rvalid); end
        next_cycle();
        bus.ext_valid = 1'b0;
        @(negedge clk);
        tests++; if (bus.ext_rvalid !== 1'b1) begin fails++; $display("FAIL rd_rvalid got %b exp 1", bus.ext_rvalid); end
        tests++; if (bus.ext_rdata !== 32'h1234_5678) begin fails++; $display("FAIL rd_rdata got %h exp 12345678", bus.ext_rdata); end
        next_cycle();
        @(negedge clk);
        tests++; if (bus.ext_rvalid !== 1'b0) begin fails++; $display("FAIL rd_rvalid_pulse got %b exp 0", bus.ext_rvalid); end
        tests++; if (bus.ext_rdata !== 32'h1234_5678) begin fails++; $display("FAIL rd_rdata_hold got %h exp 12345678", bus.ext_rdata); end
        next_cycle();
    endtask

    task automatic test_starvation();
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'h0000_0010; bus.core_wdata = 32'hA5A5_A5A5;
        bus.ext_valid = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h0000_0014; bus.ext_wdata = 32'h1111_1111;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            tests++; if (bus.ext_ready !== 1'b0 || bus.stall_m !== 1'b0) begin
                fails++; $display("FAIL starve_refuse cycle %0d got ready=%b stall=%b exp 0/0", c, bus.ext_ready, bus.stall_m);
            end
            tests++; if (bus.mem_addr !== 32'h0000_0010) begin fails++; $display("FAIL starve_core_addr cycle %0d got %h exp 00000010", c, bus.mem_addr); end
            next_cycle();
        end
        @(negedge clk);
        tests++; if (bus.ext_ready !== 1'b1 || bus.stall_m !== 1'b1) begin
            fails++; $display("FAIL starve_forced got ready=%b stall=%b exp 1/1", bus.ext_ready, bus.stall_m);
        end
        tests++; if (bus.mem_addr !== 32'h0000_0014 || bus.mem_we !== 1'b1) begin
            fails++; $display("FAIL starve_forced_port got addr=%h we=%b exp 00000014/1", bus.mem_addr, bus.mem_we);
        end
        next_cycle();
        bus.ext_valid = 1'b0;
        @(negedge clk);
        tests++; if (bus.ext_ready !== 1'b0 || bus.stall_m !== 1'b0) begin
            fails++; $display("FAIL starve_gap got ready=%b stall=%b exp 0/0", bus.ext_ready, bus.stall_m);
        end
        tests++; if (bus.mem_addr !== 32'h0000_0010 || bus.mem_we !== 1'b1) begin
            fails++; $display("FAIL starve_gap_core got addr=%h we=%b exp 00000010/1", bus.mem_addr, bus.mem_we);
        end
        next_cycle();
        idle_inputs();
        tests++; if (mem[5] !== 32'h1111_1111) begin fails++; $display("FAIL starve_ext_write got %h exp 11111111", mem[5]); end
        tests++; if (mem[4] !== 32'hA5A5_A5A5) begin fails++; $display("FAIL starve_core_write got %h exp a5a5a5a5", mem[4]); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [0:2];
        logic [31:0] datas [0:2];
        logic        exp_ready [0:5];
        logic        exp_rv [0:5];
        int          idx;
        int          rd_idx;
        addrs[0] = 32'h0000_0080; datas[0] = 32'h1234_5678;
        addrs[1] = 32'h0000_0040; datas[1] = 32'hDEAD_BEEF;
        addrs[2] = 32'h0000_0014; datas[2] = 32'h1111_1111;
        exp_ready[0] = 1'b1; exp_ready[1] = 1'b0; exp_ready[2] = 1'b1;
        exp_ready[3] = 1'b0; exp_ready[4] = 1'b1; exp_ready[5] = 1'b0;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b1; exp_rv[2] = 1'b0;
        exp_rv[3] = 1'b1; exp_rv[4] = 1'b0; exp_rv[5] = 1'b1;
        idx = 0; rd_idx = 0;
        bus.ext_valid = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = addrs[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++; if (bus.ext_ready !== exp_ready[c]) begin
                fails++; $display("FAIL b2b_ready cycle %0d got %b exp %b", c, bus.ext_ready, exp_ready[c]);
            end
            tests++; if (bus.ext_rvalid !== exp_rv[c]) begin
                fails++; $display("FAIL b2b_rvalid cycle %0d got %b exp %b", c, bus.ext_rvalid, exp_rv[c]);
            end
            if (exp_rv[c]) begin
                tests++; if (bus.ext_rdata !== datas[rd_idx]) begin
                    fails++; $display("FAIL b2b_rdata cycle %0d got %h exp %h", c, bus.ext_rdata, datas[rd_idx]);
                end
                rd_idx++;
            end
            next_cycle();
            if (exp_ready[c]) begin
                idx++;
                if (idx < 3) bus.ext_addr = addrs[idx];
                else bus.ext_valid = 1'b0;
            end
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        bus.ext_valid = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h0000_0080;
        #2;
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        tests++; if (bus.ext_rvalid !== 1'b0) begin fails++; $display("FAIL rstmid_rvalid got %b exp 0", bus.ext_rvalid); end
        tests++; if (bus.ext_rdata !== 32'h0) begin fails++; $display("FAIL rstmid_rdata got %h exp 00000000", bus.ext_rdata); end
        tests++; if (bus.ext_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready got %b exp 0", bus.ext_ready); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        tests++; if (bus.ext_ready !== 1'b1) begin fails++; $display("FAIL rstmid_idle_grant got %b exp 1", bus.ext_ready); end
        next_cycle();
        bus.ext_valid = 1'b0;
        @(negedge clk);
        tests++; if (bus.ext_rvalid !== 1'b1 || bus.ext_rdata !== 32'h1234_5678) begin
            fails++; $display("FAIL rstmid_reissue got rvalid=%b rdata=%h exp 1/12345678", bus.ext_rvalid, bus.ext_rdata);
        end
        next_cycle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        pre_we = 1'b0; pre_idx = 6'h00; pre_data = 32'h0;
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_ext_write();
        test_ext_read();
        test_starvation();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
